// File: rtl/io_interval_timer_if.sv
// Register-decoder bus and interrupt handshake for the IO interval timer.
// The bench or decoder side uses master; the timer uses slave.
interface io_interval_timer_if;
  logic        BlockSelect;
  logic [3:0]  RegAddress;
  logic        WrEn;
  logic        RdEn;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        IntReq;
  logic        IntAck;

  modport master (
    output BlockSelect, RegAddress, WrEn, RdEn, WrData, IntAck,
    input  RdData, IntReq
  );

  modport slave (
    input  BlockSelect, RegAddress, WrEn, RdEn, WrData, IntAck,
    output RdData, IntReq
  );
endinterface

// File: rtl/io_interval_timer.sv
// Programmable down-counting interval timer behind the KabIO register decoder.
// It expires one tick after COUNT reaches 0 and raises a level IRQ while EXP & IE.
module io_interval_timer #(
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned CNT_W   = 32
) (
  input logic              IO_Clock,
  input logic              IO_Reset,
  io_interval_timer_if.slave bus
);

  typedef enum logic [3:0] {
    REG_CTRL  = 4'd0,
    REG_LOAD  = 4'd1,
    REG_COUNT = 4'd2,
    REG_STAT  = 4'd3,
    REG_PRESC = 4'd4
  } reg_addr_e;

  logic               en_q, en_d;
  logic               auto_q, auto_d;
  logic               ie_q, ie_d;
  logic               exp_q, exp_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        rdata_q, rdata_d;

  logic wr_acc, rd_acc;
  logic wr_ctrl, wr_load, wr_stat, wr_presc;
  logic tick, expire;

  always_comb begin
    wr_acc   = bus.BlockSelect & bus.WrEn;
    rd_acc   = bus.BlockSelect & bus.RdEn;
    wr_ctrl  = wr_acc && (bus.RegAddress == REG_CTRL);
    wr_load  = wr_acc && (bus.RegAddress == REG_LOAD);
    wr_stat  = wr_acc && (bus.RegAddress == REG_STAT);
    wr_presc = wr_acc && (bus.RegAddress == REG_PRESC);
    tick     = en_q && (pcnt_q == presc_q);
    // A LOAD write in the same cycle swallows the tick entirely.
    expire   = tick && !wr_load && (count_q == '0);

    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    rdata_d = rdata_q;

    if (!en_q || tick) pcnt_d = '0;
    else               pcnt_d = pcnt_q + PRESC_W'(1);

    if (tick && !wr_load) begin
      if (count_q != '0)  count_d = count_q - CNT_W'(1);
      else if (auto_q)    count_d = load_q;
      else                en_d    = 1'b0;
    end

    // CTRL write is applied after the one-shot disable so it takes precedence.
    if (wr_ctrl) begin
      en_d   = bus.WrData[0];
      auto_d = bus.WrData[1];
      ie_d   = bus.WrData[2];
      if (!en_q && bus.WrData[0]) pcnt_d = '0;
    end

    if (wr_load) begin
      load_d  = bus.WrData[CNT_W-1:0];
      count_d = bus.WrData[CNT_W-1:0];
      pcnt_d  = '0;
    end

    if (wr_presc) presc_d = bus.WrData[PRESC_W-1:0];

    if (bus.IntAck || (wr_stat && bus.WrData[0])) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;

    if (rd_acc) begin
      case (bus.RegAddress)
        REG_CTRL:  rdata_d = {29'd0, ie_q, auto_q, en_q};
        REG_LOAD:  rdata_d = 32'(load_q);
        REG_COUNT: rdata_d = 32'(count_q);
        REG_STAT:  rdata_d = {31'd0, exp_q};
        REG_PRESC: rdata_d = 32'(presc_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge IO_Clock or negedge IO_Reset) begin
    if (!IO_Reset) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.RdData = rdata_q;
  assign bus.IntReq = exp_q & ie_q;

endmodule

// File: tb/tb_io_interval_timer.sv
// Directed and randomized checks of io_interval_timer against an arithmetic
// model of the period (LOAD+1)*(PRESC+1) and the count value after N clocks.
module tb_io_interval_timer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  io_interval_timer_if intf ();

  io_interval_timer #(.PRESC_W(8), .CNT_W(32)) dut (
    .IO_Clock (clk),
    .IO_Reset (rst_n),
    .bus      (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) cycle();
  endtask

  task automatic bus_op(input logic bs, input logic rd, input logic wr,
                        input logic [3:0] a, input logic [31:0] d);
    intf.BlockSelect = bs;
    intf.RdEn        = rd;
    intf.WrEn        = wr;
    intf.RegAddress  = a;
    intf.WrData      = d;
    cycle();
    intf.BlockSelect = 1'b0;
    intf.RdEn        = 1'b0;
    intf.WrEn        = 1'b0;
    intf.RegAddress  = 4'd0;
    intf.WrData      = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_op(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_op(1'b1, 1'b1, 1'b0, a, 32'd0);
    d = intf.RdData;
  endtask

  task automatic ack();
    intf.IntAck = 1'b1;
    cycle();
    intf.IntAck = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int e0;
    int unsigned p, l, a, per, k_end, ticks, exp_cnt;

    total = 0; bad = 0; cyc = 0;
    intf.BlockSelect = 1'b0; intf.RdEn = 1'b0; intf.WrEn = 1'b0;
    intf.RegAddress = 4'd0; intf.WrData = '0; intf.IntAck = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_rddata", intf.RdData, 32'd0);
    chk("rst_intreq", {31'd0, intf.IntReq}, 32'd0);
    rst_n = 1'b1;

    // Reset mid-count while IRQ is high
    wr(4'd1, 32'd2);
    wr(4'd0, 32'd7);
    cycle(); cycle(); cycle();
    chk("pre_rst_intreq", {31'd0, intf.IntReq}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_intreq", {31'd0, intf.IntReq}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rd(4'd2, r); chk("rst_count", r, 32'd0);
    rd(4'd3, r); chk("rst_stat", r, 32'd0);
    rd(4'd0, r); chk("rst_ctrl", r, 32'd0);
    rd(4'd1, r); chk("rst_load", r, 32'd0);

    // One-shot, PRESC=0, LOAD=3
    wr(4'd4, 32'd0);
    wr(4'd1, 32'd3);
    wr(4'd0, 32'd5);
    e0 = cyc;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk($sformatf("oneshot_irq_k%0d", k), {31'd0, intf.IntReq}, (k == 4) ? 32'd1 : 32'd0);
    end
    rd(4'd0, r); chk("oneshot_ctrl", r, 32'd4);
    rd(4'd2, r); chk("oneshot_count", r, 32'd0);
    wr(4'd3, 32'd1);
    chk("stat_w1c_irq", {31'd0, intf.IntReq}, 32'd0);

    // Auto-reload, PRESC=1, LOAD=2 -> period 6
    wr(4'd0, 32'd0);
    wr(4'd4, 32'd1);
    wr(4'd1, 32'd2);
    wr(4'd0, 32'd7);
    e0 = cyc;
    run_to(e0 + 5); chk("auto_irq_t5", {31'd0, intf.IntReq}, 32'd0);
    cycle();        chk("auto_irq_t6", {31'd0, intf.IntReq}, 32'd1);
    ack();          chk("auto_ack_drop", {31'd0, intf.IntReq}, 32'd0);
    run_to(e0 + 11); chk("auto_irq_t11", {31'd0, intf.IntReq}, 32'd0);
    cycle();         chk("auto_irq_t12", {31'd0, intf.IntReq}, 32'd1);
    ack();           chk("auto_ack2_drop", {31'd0, intf.IntReq}, 32'd0);

    // Clear write lands on the same edge as the expiry: set wins
    run_to(e0 + 17);
    wr(4'd3, 32'd1);
    chk("collide_irq", {31'd0, intf.IntReq}, 32'd1);
    rd(4'd3, r); chk("collide_stat", r, 32'd1);
    rd(4'd2, r); chk("reload_count", r, 32'd2);
    wr(4'd0, 32'd0);
    wr(4'd3, 32'd1);
    chk("clear_after_collide", {31'd0, intf.IntReq}, 32'd0);

    // Bus behaviour
    rd(4'd9, r); chk("reserved_rd", r, 32'd0);
    wr(4'd9, 32'hFFFF_FFFF);
    rd(4'd9, r); chk("reserved_wr_ignored", r, 32'd0);
    wr(4'd1, 32'h55);
    bus_op(1'b0, 1'b0, 1'b1, 4'd1, 32'hAA);
    bus_op(1'b0, 1'b0, 1'b1, 4'd4, 32'h3C);
    rd(4'd1, r); chk("bs0_load", r, 32'h55);
    bus_op(1'b0, 1'b1, 1'b0, 4'd9, 32'd0);
    chk("bs0_rd_hold", intf.RdData, 32'h55);
    rd(4'd4, r); chk("bs0_presc", r, 32'd1);
    bus_op(1'b1, 1'b1, 1'b1, 4'd1, 32'h1234);
    chk("rdwr_old_load", intf.RdData, 32'h55);
    rd(4'd1, r); chk("rdwr_new_load", r, 32'h1234);
    rd(4'd2, r); chk("rdwr_new_count", r, 32'h1234);

    // IE=0 expiry, then enable IE
    wr(4'd4, 32'd0);
    wr(4'd1, 32'd1);
    wr(4'd0, 32'd1);
    e0 = cyc;
    run_to(e0 + 3);
    chk("ie0_irq", {31'd0, intf.IntReq}, 32'd0);
    rd(4'd3, r); chk("ie0_stat", r, 32'd1);
    wr(4'd0, 32'd4);
    chk("ie1_irq", {31'd0, intf.IntReq}, 32'd1);
    wr(4'd3, 32'd1);

    // Randomized: IRQ timing and COUNT from period arithmetic
    for (int it = 0; it < 16; it++) begin
      p = $urandom_range(0, 3);
      l = $urandom_range(0, 5);
      a = $urandom_range(0, 1);
      wr(4'd0, 32'd0);
      wr(4'd3, 32'd1);
      wr(4'd4, p);
      wr(4'd1, l);
      wr(4'd0, (a != 0) ? 32'd7 : 32'd5);
      per   = (l + 1) * (p + 1);
      k_end = per + $urandom_range(0, 6);
      for (int unsigned k = 1; k <= k_end; k++) begin
        cycle();
        chk($sformatf("rnd%0d_irq_k%0d", it, k), {31'd0, intf.IntReq},
            (k >= per) ? 32'd1 : 32'd0);
      end
      ticks = k_end / (p + 1);
      if (a != 0) exp_cnt = l - (ticks % (l + 1));
      else        exp_cnt = (ticks >= l) ? 0 : l - ticks;
      rd(4'd2, r); chk($sformatf("rnd%0d_count", it), r, exp_cnt);
      rd(4'd0, r); chk($sformatf("rnd%0d_ctrl", it), r, (a != 0) ? 32'd7 : 32'd4);
    end
    wr(4'd0, 32'd0);
    wr(4'd3, 32'd1);
    chk("final_irq", {31'd0, intf.IntReq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
